// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types and level/vector helpers for the PIC priority stage
package pic_pkg;

    localparam int PIC_NUM_IRQ = 8;
    localparam int PIC_LVL_W   = 3;

    typedef logic [PIC_NUM_IRQ-1:0] irq_vec_t;
    typedef logic [PIC_LVL_W-1:0]   irq_lvl_t;

    function automatic irq_vec_t lvl2onehot(input irq_lvl_t lvl);
        irq_vec_t v;
        v = '0;
        v[lvl] = 1'b1;
        return v;
    endfunction

    function automatic irq_lvl_t onehot2lvl(input irq_vec_t v);
        irq_lvl_t lvl;
        lvl = '0;
        for (int i = 0; i < PIC_NUM_IRQ; i++) begin
            if (v[i]) lvl = irq_lvl_t'(i);
        end
        return lvl;
    endfunction

    function automatic irq_vec_t rotate_right(input irq_vec_t v, input irq_lvl_t lvl);
        logic [2*PIC_NUM_IRQ-1:0] w;
        w = {v, v} >> lvl;
        return w[PIC_NUM_IRQ-1:0];
    endfunction

    function automatic irq_vec_t rotate_left(input irq_vec_t v, input irq_lvl_t lvl);
        logic [2*PIC_NUM_IRQ-1:0] w;
        w = {v, v} << lvl;
        return w[2*PIC_NUM_IRQ-1:PIC_NUM_IRQ];
    endfunction

    // Position in the priority order below ptr: 0 is the highest priority level.
    function automatic irq_lvl_t prio_rank(input irq_lvl_t lvl, input irq_lvl_t ptr);
        return lvl - ptr - 3'd1;
    endfunction

endpackage

// File: rtl/pic_irq_priority_if.sv
// rtl/pic_irq_priority_if.sv - control-block strobes in, request/status back to control
interface pic_irq_priority_if;
    import pic_pkg::*;

    logic     level_edge_triggered;
    irq_vec_t int_mask;
    irq_vec_t eoi;
    logic     latch_in_service;
    logic     clear_all;
    logic     priority_rotate;
    irq_lvl_t priority_bottom;

    logic     interrupt_request;
    irq_vec_t highest_level_in_service;
    irq_vec_t irr;
    irq_vec_t isr;
    irq_vec_t acknowledge_interrupt;

    modport master (
        output level_edge_triggered, int_mask, eoi, latch_in_service, clear_all,
               priority_rotate, priority_bottom,
        input  interrupt_request, highest_level_in_service, irr, isr, acknowledge_interrupt
    );

    modport slave (
        input  level_edge_triggered, int_mask, eoi, latch_in_service, clear_all,
               priority_rotate, priority_bottom,
        output interrupt_request, highest_level_in_service, irr, isr, acknowledge_interrupt
    );

endinterface

// File: rtl/pic_priority_encoder.sv
// rtl/pic_priority_encoder.sv - rotated find-first-set; highest priority is ptr+1
module pic_priority_encoder
    import pic_pkg::*;
(
    input  irq_vec_t vec,
    input  irq_lvl_t ptr,
    output irq_vec_t onehot,
    output logic     valid
);

    irq_lvl_t lvl;

    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        lvl    = '0;
        for (int i = 0; i < PIC_NUM_IRQ; i++) begin
            lvl = ptr + irq_lvl_t'(i + 1);
            if (!valid && vec[lvl]) begin
                onehot = lvl2onehot(lvl);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pic_irq_priority.sv
// rtl/pic_irq_priority.sv - IRR/ISR/priority resolution; rotation under PIC_PRIORITY_ROTATE_EN
module pic_irq_priority
    import pic_pkg::*;
#(
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  irq_vec_t                 irq,
    pic_irq_priority_if.slave        ctl
);

    irq_vec_t irq_s;
    irq_vec_t irq_d_q, irq_d_d;
    irq_vec_t irr_q, irr_d;
    irq_vec_t isr_q, isr_d;
    irq_vec_t ack_q, ack_d;
    logic     int_req_q, int_req_d;
    irq_lvl_t ptr;

    generate
        if (IRQ_SYNC_STAGES == 0) begin : g_nosync
            assign irq_s = irq;
        end else begin : g_sync
            irq_vec_t sync_q [IRQ_SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < IRQ_SYNC_STAGES; k++) sync_q[k] <= '0;
                end else begin
                    sync_q[0] <= irq;
                    for (int k = 1; k < IRQ_SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
                end
            end
            assign irq_s = sync_q[IRQ_SYNC_STAGES-1];
        end
    endgenerate

`ifdef PIC_PRIORITY_ROTATE_EN
    irq_lvl_t ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    logic unused_rotate;
    assign ptr           = 3'd7;
    assign unused_rotate = ^{ctl.priority_rotate, ctl.priority_bottom};
`endif

    irq_vec_t cand, win_oh, isr_oh, latched;
    logic     win_found, isr_found, winner_valid;

    assign cand = irr_q & ~ctl.int_mask;

    pic_priority_encoder u_cand_enc (.vec(cand),  .ptr(ptr), .onehot(win_oh), .valid(win_found));
    pic_priority_encoder u_isr_enc  (.vec(isr_q), .ptr(ptr), .onehot(isr_oh), .valid(isr_found));

    // Fully nested: an equal rank means the winner is itself in service, so it is blocked.
    assign winner_valid = win_found &&
        (!isr_found || (prio_rank(onehot2lvl(win_oh), ptr) < prio_rank(onehot2lvl(isr_oh), ptr)));
    assign latched = (ctl.latch_in_service && winner_valid) ? win_oh : '0;

    always_comb begin
        irq_d_d   = irq_s;
        int_req_d = winner_valid;
        isr_d     = (isr_q & ~ctl.eoi) | latched;
        ack_d     = ack_q;
        if (ctl.level_edge_triggered) irr_d = irq_s;
        else                          irr_d = (irr_q | (irq_s & ~irq_d_q)) & irq_s & ~latched;
        if (ctl.latch_in_service) ack_d = winner_valid ? win_oh : lvl2onehot(3'd7);
`ifdef PIC_PRIORITY_ROTATE_EN
        ptr_d = ctl.priority_rotate ? ctl.priority_bottom : ptr_q;
`endif
        if (ctl.clear_all) begin
            irr_d     = '0;
            isr_d     = '0;
            ack_d     = '0;
            int_req_d = 1'b0;
`ifdef PIC_PRIORITY_ROTATE_EN
            ptr_d     = 3'd7;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d_q   <= '0;
            irr_q     <= '0;
            isr_q     <= '0;
            ack_q     <= '0;
            int_req_q <= 1'b0;
`ifdef PIC_PRIORITY_ROTATE_EN
            ptr_q     <= 3'd7;
`endif
        end else begin
            irq_d_q   <= irq_d_d;
            irr_q     <= irr_d;
            isr_q     <= isr_d;
            ack_q     <= ack_d;
            int_req_q <= int_req_d;
`ifdef PIC_PRIORITY_ROTATE_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign ctl.interrupt_request        = int_req_q;
    assign ctl.highest_level_in_service = isr_oh;
    assign ctl.irr                      = irr_q;
    assign ctl.isr                      = isr_q;
    assign ctl.acknowledge_interrupt    = ack_q;

endmodule

// File: tb/tb_pic_irq_priority.sv
// tb/tb_pic_irq_priority.sv - directed checks of request, nesting, masking, EOI and clear
module tb_pic_irq_priority;
    import pic_pkg::*;

    logic     clk = 1'b0;
    logic     reset;
    irq_vec_t irq;
    int       passed = 0;
    int       total  = 0;

    pic_irq_priority_if ctl_if ();

    pic_irq_priority #(.IRQ_SYNC_STAGES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .irq  (irq),
        .ctl  (ctl_if)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        irq = '0;
        ctl_if.level_edge_triggered = 1'b0;
        ctl_if.int_mask = '0;
        ctl_if.eoi = '0;
        ctl_if.latch_in_service = 1'b0;
        ctl_if.clear_all = 1'b0;
        ctl_if.priority_rotate = 1'b0;
        ctl_if.priority_bottom = '0;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic pulse_latch();
        ctl_if.latch_in_service = 1'b1;
        tick(1);
        ctl_if.latch_in_service = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL rst_int_req got %b exp 0", ctl_if.interrupt_request); else passed++;
        total++; if ({ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt, ctl_if.highest_level_in_service} !== 32'h0)
            $display("FAIL rst_outputs got %h exp 0", {ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt, ctl_if.highest_level_in_service}); else passed++;
        irq = 8'h04; tick(4);
        pulse_latch();
        irq = 8'h00;
        reset = 1'b1; tick(2);
        total++; if ({ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt, 7'h0, ctl_if.interrupt_request} !== 32'h0)
            $display("FAIL midrst_outputs got %h exp 0", {ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt}); else passed++;
        reset = 1'b0; tick(5);
        total++; if ({ctl_if.irr, ctl_if.isr, 7'h0, ctl_if.interrupt_request} !== 24'h0)
            $display("FAIL midrst_residual got %h exp 0", {ctl_if.irr, ctl_if.isr, ctl_if.interrupt_request}); else passed++;
    endtask

    task automatic test_edge_latch();
        do_reset();
        irq = 8'h08; tick(2);
        total++; if (ctl_if.irr !== 8'h00) $display("FAIL edge_irr_early got %h exp 00", ctl_if.irr); else passed++;
        tick(1);
        total++; if (ctl_if.irr !== 8'h08) $display("FAIL edge_irr got %h exp 08", ctl_if.irr); else passed++;
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL edge_req_early got %b exp 0", ctl_if.interrupt_request); else passed++;
        tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b1) $display("FAIL edge_req got %b exp 1", ctl_if.interrupt_request); else passed++;
        pulse_latch();
        total++; if (ctl_if.isr !== 8'h08) $display("FAIL edge_isr got %h exp 08", ctl_if.isr); else passed++;
        total++; if (ctl_if.acknowledge_interrupt !== 8'h08) $display("FAIL edge_ack got %h exp 08", ctl_if.acknowledge_interrupt); else passed++;
        total++; if (ctl_if.irr !== 8'h00) $display("FAIL edge_irr_clr got %h exp 00", ctl_if.irr); else passed++;
        total++; if (ctl_if.highest_level_in_service !== 8'h08) $display("FAIL edge_hlis got %h exp 08", ctl_if.highest_level_in_service); else passed++;
        tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL edge_req_drop got %b exp 0", ctl_if.interrupt_request); else passed++;
    endtask

    task automatic test_priority_eoi();
        do_reset();
        irq = 8'h24; tick(4);
        pulse_latch();
        total++; if (ctl_if.isr !== 8'h04) $display("FAIL prio_isr1 got %h exp 04", ctl_if.isr); else passed++;
        total++; if (ctl_if.irr !== 8'h20) $display("FAIL prio_irr1 got %h exp 20", ctl_if.irr); else passed++;
        ctl_if.eoi = 8'h04; tick(1); ctl_if.eoi = 8'h00;
        total++; if (ctl_if.isr !== 8'h00) $display("FAIL prio_eoi got %h exp 00", ctl_if.isr); else passed++;
        pulse_latch();
        total++; if (ctl_if.isr !== 8'h20) $display("FAIL prio_isr2 got %h exp 20", ctl_if.isr); else passed++;
        total++; if (ctl_if.highest_level_in_service !== 8'h20) $display("FAIL prio_hlis2 got %h exp 20", ctl_if.highest_level_in_service); else passed++;
    endtask

    task automatic test_nesting();
        do_reset();
        irq = 8'h04; tick(4);
        pulse_latch();
        irq = 8'h06; tick(3);
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL nest_req_early got %b exp 0", ctl_if.interrupt_request); else passed++;
        tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b1) $display("FAIL nest_req got %b exp 1", ctl_if.interrupt_request); else passed++;
        pulse_latch();
        total++; if (ctl_if.isr !== 8'h06) $display("FAIL nest_isr got %h exp 06", ctl_if.isr); else passed++;
        total++; if (ctl_if.highest_level_in_service !== 8'h02) $display("FAIL nest_hlis got %h exp 02", ctl_if.highest_level_in_service); else passed++;
        do_reset();
        irq = 8'h04; tick(4);
        pulse_latch();
        irq = 8'h24; tick(5);
        total++; if (ctl_if.irr !== 8'h20) $display("FAIL nest_low_irr got %h exp 20", ctl_if.irr); else passed++;
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL nest_low_req got %b exp 0", ctl_if.interrupt_request); else passed++;
    endtask

    task automatic test_mask_spurious();
        do_reset();
        ctl_if.int_mask = 8'h10; irq = 8'h10; tick(5);
        total++; if (ctl_if.irr !== 8'h10) $display("FAIL mask_irr got %h exp 10", ctl_if.irr); else passed++;
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL mask_req got %b exp 0", ctl_if.interrupt_request); else passed++;
        ctl_if.int_mask = 8'h00; tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b1) $display("FAIL unmask_req got %b exp 1", ctl_if.interrupt_request); else passed++;
        ctl_if.int_mask = 8'h10;
        pulse_latch();
        total++; if (ctl_if.acknowledge_interrupt !== 8'h80) $display("FAIL spur_ack got %h exp 80", ctl_if.acknowledge_interrupt); else passed++;
        total++; if (ctl_if.isr !== 8'h00) $display("FAIL spur_isr got %h exp 00", ctl_if.isr); else passed++;
        total++; if (ctl_if.irr !== 8'h10) $display("FAIL spur_irr got %h exp 10", ctl_if.irr); else passed++;
    endtask

    task automatic test_level_mode();
        do_reset();
        ctl_if.level_edge_triggered = 1'b1; irq = 8'h04; tick(3);
        total++; if (ctl_if.irr !== 8'h04) $display("FAIL lvl_irr got %h exp 04", ctl_if.irr); else passed++;
        tick(1);
        pulse_latch();
        total++; if (ctl_if.irr !== 8'h04) $display("FAIL lvl_irr_held got %h exp 04", ctl_if.irr); else passed++;
        total++; if (ctl_if.isr !== 8'h04) $display("FAIL lvl_isr got %h exp 04", ctl_if.isr); else passed++;
        tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b0) $display("FAIL lvl_req_blocked got %b exp 0", ctl_if.interrupt_request); else passed++;
        ctl_if.eoi = 8'h04; tick(1); ctl_if.eoi = 8'h00;
        tick(1);
        total++; if (ctl_if.interrupt_request !== 1'b1) $display("FAIL lvl_req_again got %b exp 1", ctl_if.interrupt_request); else passed++;
    endtask

    task automatic test_clear_all();
        do_reset();
        irq = 8'h06; tick(4);
        pulse_latch();
        total++; if (ctl_if.acknowledge_interrupt !== 8'h02) $display("FAIL clr_pre_ack got %h exp 02", ctl_if.acknowledge_interrupt); else passed++;
        ctl_if.clear_all = 1'b1; ctl_if.latch_in_service = 1'b1; tick(1);
        ctl_if.clear_all = 1'b0; ctl_if.latch_in_service = 1'b0;
        total++; if ({ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt, ctl_if.highest_level_in_service, 7'h0, ctl_if.interrupt_request} !== 40'h0)
            $display("FAIL clr_outputs got %h exp 0", {ctl_if.irr, ctl_if.isr, ctl_if.acknowledge_interrupt, ctl_if.highest_level_in_service, ctl_if.interrupt_request}); else passed++;
        tick(5);
        total++; if ({ctl_if.irr, 7'h0, ctl_if.interrupt_request} !== 16'h0) $display("FAIL clr_no_req got %h exp 0", {ctl_if.irr, ctl_if.interrupt_request}); else passed++;
        irq = 8'h00; tick(3);
        irq = 8'h04; tick(4);
        total++; if (ctl_if.irr !== 8'h04) $display("FAIL clr_fresh_irr got %h exp 04", ctl_if.irr); else passed++;
        total++; if (ctl_if.interrupt_request !== 1'b1) $display("FAIL clr_fresh_req got %b exp 1", ctl_if.interrupt_request); else passed++;
    endtask

    task automatic test_rotate();
`ifdef PIC_PRIORITY_ROTATE_EN
        irq_vec_t exp_b0 = 8'h08;
`else
        irq_vec_t exp_b0 = 8'h01;
`endif
        do_reset();
        ctl_if.priority_bottom = 3'd3; ctl_if.priority_rotate = 1'b1; tick(1); ctl_if.priority_rotate = 1'b0;
        irq = 8'h09; tick(4);
        pulse_latch();
        total++; if (ctl_if.isr !== 8'h01) $display("FAIL rot_b3_isr got %h exp 01", ctl_if.isr); else passed++;
        do_reset();
        ctl_if.priority_bottom = 3'd0; ctl_if.priority_rotate = 1'b1; tick(1); ctl_if.priority_rotate = 1'b0;
        irq = 8'h09; tick(4);
        pulse_latch();
        total++; if (ctl_if.isr !== exp_b0) $display("FAIL rot_b0_isr got %h exp %h", ctl_if.isr, exp_b0); else passed++;
    endtask

    initial begin
        test_reset();
        test_edge_latch();
        test_priority_eoi();
        test_nesting();
        test_mask_spurious();
        test_level_mode();
        test_clear_all();
        test_rotate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
